// File: rtl/hex_display_scanner.sv
// Eight-digit hex scanner for a common-anode multiplexed 7-segment display.
// Shadows the input word once per frame so a frame never mixes two values.
module hex_display_scanner #(
   parameter int SCAN_DIV = 100000,
   parameter bit DP_MID   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] data_i,
   input  logic        blank_lz_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        frame_o
);

   // state   | meaning
   // ST_OFF  | display dark, prescaler/idx held at 0, waiting for en_i
   // ST_SCAN | cycling through digits 0..7, reloading shadow at end of frame

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   typedef enum logic {ST_OFF, ST_SCAN} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shadow_q, shadow_d;
   logic          lz_q, lz_d;
   logic          frame_q, frame_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick;
   logic          load;
   logic [31:0]   upper;
   logic [3:0]    nib;
   logic          blank;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_OFF;
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         lz_q     <= 1'b0;
         frame_q  <= 1'b0;
         an_q     <= 8'hFF;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         lz_q     <= lz_d;
         frame_q  <= frame_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      lz_d     = lz_q;
      tick     = (presc_q == PRESC_MAX);
      load     = 1'b0;
      if (!en_i) begin
         state_d = ST_OFF;
         presc_d = '0;
         idx_d   = '0;
      end else if (state_q == ST_OFF) begin
         state_d = ST_SCAN;
         presc_d = '0;
         idx_d   = '0;
         load    = 1'b1;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            idx_d = idx_q + 3'd1;
            load  = (idx_q == 3'd7);
         end
      end
      if (load) begin
         shadow_d = data_i;
         lz_d     = blank_lz_i;
      end
      frame_d = load;
   end

   // Output decode is registered; a falling en_i darkens the display on the very next edge.
   always_comb begin
      upper = shadow_q >> {idx_q, 2'b00};
      nib   = shadow_q[{idx_q, 2'b00} +: 4];
      blank = lz_q && (idx_q != 3'd0) && (upper == 32'd0);
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if ((state_q == ST_SCAN) && en_i && !blank) begin
         an_d  = ~(8'b1 << idx_q);
         seg_d = hex_seg(nib);
         dp_d  = !(DP_MID && (idx_q == 3'd4));
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with SCAN_DIV=4, DP_MID=1.
// A cycle model pushes expected outputs per edge; they are popped and compared after the edge.
module tb_hex_display_scanner;

   localparam int SD = 4;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        en_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        blank_lz_i = 1'b0;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        frame_o;

   hex_display_scanner #(.SCAN_DIV(SD), .DP_MID(1'b1)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .data_i     (data_i),
      .blank_lz_i (blank_lz_i),
      .an_o       (an_o),
      .seg_o      (seg_o),
      .dp_o       (dp_o),
      .frame_o    (frame_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          m_scan;
   int          m_presc;
   int          m_idx;
   logic [31:0] m_shadow;
   bit          m_lz;
   bit          last_frame;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_scan   = 1'b0;
      m_presc  = 0;
      m_idx    = 0;
      m_shadow = '0;
      m_lz     = 1'b0;
      sb.delete();
   endtask

   task automatic step();
      exp_t e;
      exp_t got;
      bit   blank;
      bit   tick;
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
      if (m_scan && en_i) begin
         blank = m_lz && (m_idx != 0);
         for (int k = m_idx; k < 8; k++)
            if (m_shadow[4*k +: 4] != 4'h0) blank = 1'b0;
         if (!blank) begin
            e.an[m_idx] = 1'b0;
            e.seg = SEG_TAB[m_shadow[4*m_idx +: 4]];
            e.dp  = !(m_idx == 4);
         end
      end
      tick    = (m_presc == SD - 1);
      e.frame = en_i && (!m_scan || (tick && m_idx == 7));
      if (e.frame) begin
         m_shadow = data_i;
         m_lz     = blank_lz_i;
      end
      if (!en_i) begin
         m_scan = 1'b0; m_presc = 0; m_idx = 0;
      end else if (!m_scan) begin
         m_scan = 1'b1; m_presc = 0; m_idx = 0;
      end else begin
         m_presc = tick ? 0 : m_presc + 1;
         if (tick) m_idx = (m_idx + 1) % 8;
      end
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      got.an = an_o; got.seg = seg_o; got.dp = dp_o; got.frame = frame_o;
      e = sb.pop_front();
      last_frame = e.frame;
      chk("an_o", {24'd0, got.an}, {24'd0, e.an});
      chk("seg_o", {25'd0, got.seg}, {25'd0, e.seg});
      chk("dp_o", {31'd0, got.dp}, {31'd0, e.dp});
      chk("frame_o", {31'd0, got.frame}, {31'd0, e.frame});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_idx(input int target);
      bit hit = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (m_scan && m_idx == target && m_presc == 0) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      chk("reach_idx", {31'd0, hit}, 32'd1);
   endtask

   task automatic run_until_frame();
      bit hit = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (last_frame) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reach_frame", {31'd0, hit}, 32'd1);
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_an"}, {24'd0, an_o}, 32'h0000_00FF);
      chk({tag, "_seg"}, {25'd0, seg_o}, 32'h0000_007F);
      chk({tag, "_dp"}, {31'd0, dp_o}, 32'd1);
      chk({tag, "_frame"}, {31'd0, frame_o}, 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      en_i = 1'b1;
      data_i = 32'h1234_ABCD;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         check_dark("reset");
      end

      // Reset release and en_i high in the same cycle
      rst_i = 1'b1;
      run(40);

      // data change at digit 3 must not reach digits 4..7 before the next frame
      run_until_idx(3);
      data_i = 32'hFFFF_FFFF;
      run(40);

      blank_lz_i = 1'b1;
      data_i = 32'h0000_00A5;
      run(72);
      data_i = 32'h0000_0000;
      run(64);

      blank_lz_i = 1'b0;
      data_i = 32'h8765_4321;
      run_until_idx(5);
      run(2);
      en_i = 1'b0;
      run(3);
      en_i = 1'b1;
      run(40);

      // Async reset right after a frame pulse, between edges
      run_until_frame();
      #2;
      rst_i = 1'b0;
      #1;
      check_dark("async_rst");
      model_reset();
      @(posedge clk_i);
      #1;
      check_dark("rst_hold");
      data_i = 32'h1234_ABCD;
      rst_i = 1'b1;
      run(40);

      data_i = 32'h7654_3210;
      run(40);
      data_i = 32'hFEDC_BA98;
      run(72);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
